// File: rtl/fetch_unit.sv
// Instruction fetch unit: pc register, combinational imem lookup, and an in-order FIFO toward decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets raise a sticky fetch_misalign and stop fetching.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0004,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_misalign
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             misalign_q, misalign_d;
    logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]      fifo_pc_d    [FIFO_DEPTH];
    logic [31:0]      fifo_instr_q [FIFO_DEPTH];
    logic [31:0]      fifo_instr_d [FIFO_DEPTH];
    logic [31:0]      redir_target;
    logic             push, pop;

    assign imem_addr      = {2'b00, pc_q[31:2]};
    assign if_valid       = (count_q != '0);
    assign if_pc          = if_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    assign if_instr       = if_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign fetch_misalign = misalign_q;

    assign pop  = if_valid && if_ready;
    assign push = !redirect_valid && !halt && !misalign_q && ((count_q < FULL_CNT) || pop);

    always_comb begin
        pc_d         = pc_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_instr_d = fifo_instr_q;
`ifdef FETCH_ALIGN_CHECK_EN
        redir_target = redirect_pc;
        misalign_d   = misalign_q | (redirect_valid && (redirect_pc[1:0] != 2'b00));
`else
        redir_target = redirect_pc & ~32'h3;
        misalign_d   = 1'b0;
`endif
        if (redirect_valid) begin
            // Flush wins over any handshake this cycle; the popped head is simply lost.
            pc_d     = redir_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_pc_d[wr_ptr_q]    = pc_q;
                fifo_instr_d[wr_ptr_q] = imem_instr;
                wr_ptr_d               = wr_ptr_q + PTR_W'(1);
                pc_d                   = pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            misalign_q   <= 1'b0;
            fifo_pc_q    <= '{default: '0};
            fifo_instr_q <= '{default: '0};
        end else begin
            pc_q         <= pc_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            misalign_q   <= misalign_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_instr_q <= fifo_instr_d;
        end
    end

endmodule
